// File: rtl/ctr_uart_pkg.sv
// ============================================================================
// Module      : ctr_uart_pkg
// Description : Shared types and constants for the counter UART reporter.
//               Holds the frame FSM state enum, the frame length and the
//               parity helper. Optional feature macro: CTR_UART_PARITY_EN
//               (adds an even-parity bit after d7).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctr_uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef CTR_UART_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/ctr_uart_reporter_if.sv
// ============================================================================
// Module      : ctr_uart_reporter_if
// Description : Signal bundle between the counter stage / pad and the UART
//               reporter.
//   ctr_in     : live counter value          (master -> slave)
//   report_req : request a report            (master -> slave)
//   tx         : UART line, idle high        (slave  -> master)
//   tx_oeb     : pad output enable, active-low (slave -> master)
//   busy       : report in flight            (slave  -> master)
//   done       : one-cycle completion pulse  (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctr_uart_reporter_if #(
  parameter int COUNTER_WIDTH = 24
);
  logic [COUNTER_WIDTH-1:0] ctr_in;
  logic                     report_req;
  logic                     tx;
  logic                     tx_oeb;
  logic                     busy;
  logic                     done;

  modport master (
    output ctr_in, report_req,
    input  tx, tx_oeb, busy, done
  );

  modport slave (
    input  ctr_in, report_req,
    output tx, tx_oeb, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module      : uart_tx_byte
// Description : One-frame UART serialiser: start(0), d0..d7 LSB first,
//               optional even parity (CTR_UART_PARITY_EN), stop(1). Each bit
//               is held CLKS_PER_BIT cycles.
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : load i_data and begin a frame (honoured in IDLE and in the
//                  final stop-bit cycle, giving back-to-back frames)
//   i_data       : byte to send
//   o_tx         : serial line, high when idle
//   o_frame_done : high during the final cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
  import ctr_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_frame_done
);

  localparam int                  c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [c_baud_w-1:0] r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                w_bit_end;
  logic                w_load;
`ifdef CTR_UART_PARITY_EN
  logic                r_parity;
`endif

  assign w_bit_end = (r_baud == c_baud_last);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = START;
          w_load       = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef CTR_UART_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef CTR_UART_PARITY_EN
      PARITY: begin
        if (w_bit_end) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          // Chaining straight into the next start bit avoids an idle gap.
          if (i_start) begin
            w_state_next = START;
            w_load       = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
`ifdef CTR_UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;

      // Baud counter rests at 0 in IDLE so a new frame starts on a clean count.
      if ((r_state == IDLE) || w_bit_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + c_baud_w'(1);
      end

      if (w_load) begin
        r_shift  <= i_data;
        r_bit    <= '0;
`ifdef CTR_UART_PARITY_EN
        r_parity <= even_parity(i_data);
`endif
      end else if ((r_state == DATA) && w_bit_end) begin
        // r_bit wraps 7 -> 0 naturally as the last data bit ends.
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    unique case (r_state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = r_shift[0];
`ifdef CTR_UART_PARITY_EN
      PARITY:  o_tx = r_parity;
`endif
      default: o_tx = 1'b1;
    endcase
  end

  assign o_frame_done = (r_state == STOP) && w_bit_end;

endmodule

`default_nettype wire

// File: rtl/ctr_uart_reporter.sv
// ============================================================================
// Module      : ctr_uart_reporter
// Description : Snapshots a free-running counter on request and sends it out
//               as UART frames, most-significant byte first, on one pad.
//               Optional feature macro: CTR_UART_PARITY_EN (8E1 framing).
//   clk  : single clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : ctr_uart_reporter_if.slave - ctr_in, report_req in;
//          tx, tx_oeb, busy, done out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctr_uart_reporter
  import ctr_uart_pkg::*;
#(
  parameter int COUNTER_WIDTH = 24,
  parameter int CLKS_PER_BIT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  ctr_uart_reporter_if.slave  bus
);

  localparam int                 c_nbytes   = COUNTER_WIDTH / DATA_BITS;
  localparam int                 c_idx_w    = $clog2(c_nbytes) + 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nbytes - 1);

  if ((COUNTER_WIDTH % 8 != 0) || (COUNTER_WIDTH < 8)) begin : g_bad_width
    $error("ctr_uart_reporter: COUNTER_WIDTH must be a non-zero multiple of 8");
  end

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("ctr_uart_reporter: CLKS_PER_BIT must be >= 2");
  end

  logic [COUNTER_WIDTH-1:0] r_snap;
  logic                     r_busy;
  logic                     r_done;
  logic [c_idx_w-1:0]       r_byte_idx;
  logic [c_idx_w-1:0]       w_next_idx;
  logic                     w_accept;
  logic                     w_last_byte;
  logic                     w_start;
  logic                     w_frame_done;
  logic                     w_tx;
  logic [7:0]               w_next_byte;
  logic [7:0]               w_tx_byte;

  assign w_accept    = !r_busy && bus.report_req;
  assign w_last_byte = (r_byte_idx == c_last_idx);
  assign w_next_idx  = r_byte_idx + c_idx_w'(1);

  // Byte following the one on the line; zero once the last byte is in flight.
  always_comb begin
    w_next_byte = 8'h00;
    for (int i = 0; i < c_nbytes; i++) begin
      if (w_next_idx == c_idx_w'(i)) begin
        w_next_byte = r_snap[COUNTER_WIDTH-1-8*i -: 8];
      end
    end
  end

  // The first byte comes straight from ctr_in so its start bit can appear
  // the cycle after the accept edge, while snap is still being written.
  assign w_tx_byte = w_accept ? bus.ctr_in[COUNTER_WIDTH-1 -: 8] : w_next_byte;
  assign w_start   = w_accept || (r_busy && w_frame_done && !w_last_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_snap     <= bus.ctr_in;
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
      end else if (r_busy && w_frame_done) begin
        if (w_last_byte) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_byte_idx <= w_next_idx;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_data       (w_tx_byte),
    .o_tx         (w_tx),
    .o_frame_done (w_frame_done)
  );

  assign bus.tx     = w_tx;
  assign bus.tx_oeb = 1'b0;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ctr_uart_reporter.sv
// ============================================================================
// Module      : tb_ctr_uart_reporter
// Description : Self-checking bench for ctr_uart_reporter (CLKS_PER_BIT=4,
//               24-bit counter). Expected bytes go into a scoreboard queue
//               when a request is driven; an independent UART receiver pops
//               and compares them. Honours CTR_UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctr_uart_reporter;

  localparam int CW  = 24;
  localparam int CPB = 4;
  localparam int NB  = CW / 8;
`ifdef CTR_UART_PARITY_EN
  localparam int FB  = 11;
`else
  localparam int FB  = 10;
`endif
  localparam int RC  = NB * FB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctr_uart_reporter_if #(.COUNTER_WIDTH(CW)) u_if ();

  ctr_uart_reporter #(
    .COUNTER_WIDTH (CW),
    .CLKS_PER_BIT  (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input logic [CW-1:0] v);
    for (int i = NB - 1; i >= 0; i--) sb.push_back(v[i*8 +: 8]);
  endtask

  // ---------------- line / status monitor ----------------
  bit   mon_en = 0;
  int   viol = 0, busy_run = 0, last_busy_len = 0, idle_run = 0, last_idle_gap = 0, done_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (u_if.tx_oeb !== 1'b0) viol++;
      if (u_if.busy !== 1'b1 && u_if.tx !== 1'b1) viol++;
      if (u_if.done === 1'b1) done_cnt++;
      if (u_if.busy === 1'b1) begin
        if (!prev_busy) last_idle_gap = idle_run;
        busy_run++;
        idle_run = 0;
      end else begin
        if (prev_busy) last_busy_len = busy_run;
        busy_run = 0;
        idle_run++;
      end
      prev_busy = (u_if.busy === 1'b1);
    end
  end

  // ---------------- UART receiver (mid-bit sampling) ----------------
  bit          rx_on = 0;
  int          rx_cnt = 0;
  logic [FB-1:0] rx_frame;

  task automatic check_frame();
    logic [7:0] d;
    d = rx_frame[8:1];
    chk("start_bit", rx_frame[0], 1'b0);
    chk("stop_bit", rx_frame[FB-1], 1'b1);
`ifdef CTR_UART_PARITY_EN
    chk("parity_bit", rx_frame[9], ^d);
`endif
    chk("sb_has_entry", sb.size() > 0, 1'b1);
    if (sb.size() > 0) chk("rx_byte", d, sb.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (mon_en && u_if.tx === 1'b0) begin
        rx_on  = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_frame[rx_cnt / CPB] = u_if.tx;
        if (rx_cnt / CPB == FB - 1) begin
          rx_on = 0;
          check_frame();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (u_if.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 2000, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [CW-1:0] v;

    u_if.ctr_in     = '0;
    u_if.report_req = 1'b0;
    rst             = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1;
    chk("reset_tx", u_if.tx, 1'b1);
    chk("reset_busy", u_if.busy, 1'b0);
    chk("reset_done", u_if.done, 1'b0);
    chk("reset_oeb", u_if.tx_oeb, 1'b0);

    // Single report of A53C0F
    tick();
    d0 = done_cnt;
    u_if.ctr_in = 24'hA53C0F;
    u_if.report_req = 1'b1;
    push_bytes(24'hA53C0F);
    tick();
    u_if.report_req = 1'b0;
    @(negedge clk);
    chk("t1_busy_rise", u_if.busy, 1'b1);
    chk("t1_start_bit", u_if.tx, 1'b0);
    wait_done("t1_done_seen");
    repeat (3) @(negedge clk);
    chk("t1_busy_len", last_busy_len, RC);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // Request held high: two back-to-back reports, each with its own accept value
    tick();
    d0 = done_cnt;
    for (int k = 0; k < 2 * (RC + 1); k++) begin
      u_if.report_req = 1'b1;
      u_if.ctr_in = 24'h100000 + 24'(k) * 24'h010203;
      if (k == 0 || k == RC + 1) push_bytes(u_if.ctr_in);
      tick();
    end
    u_if.report_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_done_pulses", done_cnt - d0, 2);
    chk("t2_idle_gap", last_idle_gap, 1);
    chk("t2_busy_len", last_busy_len, RC);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_idle_busy", u_if.busy, 1'b0);

    // ctr_in scrambled every cycle during the report
    tick();
    d0 = done_cnt;
    v = 24'h5AC381;
    u_if.ctr_in = v;
    u_if.report_req = 1'b1;
    push_bytes(v);
    tick();
    u_if.report_req = 1'b0;
    for (int k = 0; k < RC + 5; k++) begin
      u_if.ctr_in = 24'($urandom);
      tick();
    end
    @(negedge clk);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_busy_len", last_busy_len, RC);

    // Request pulse at cycle 30 of a report is ignored
    tick();
    d0 = done_cnt;
    v = 24'h81FE42;
    u_if.ctr_in = v;
    u_if.report_req = 1'b1;
    push_bytes(v);
    tick();
    u_if.report_req = 1'b0;
    repeat (29) tick();
    u_if.report_req = 1'b1;
    u_if.ctr_in = 24'h111111;
    tick();
    u_if.report_req = 1'b0;
    wait_done("t4_done_seen");
    repeat (20) @(negedge clk);
    chk("t4_done_pulses", done_cnt - d0, 1);
    chk("t4_no_second", u_if.busy, 1'b0);
    chk("t4_sb_empty", sb.size(), 0);

    // Reset at cycle 50 abandons the report
    tick();
    v = 24'hC0FFEE;
    u_if.ctr_in = v;
    u_if.report_req = 1'b1;
    push_bytes(v);
    tick();
    u_if.report_req = 1'b0;
    repeat (48) tick();
    rst = 1'b1;
    sb.delete();
    d0 = done_cnt;
    tick();
    @(negedge clk);
    chk("t5_rst_tx", u_if.tx, 1'b1);
    chk("t5_rst_busy", u_if.busy, 1'b0);
    chk("t5_rst_done", u_if.done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_done_on_rst", done_cnt - d0, 0);

    // Clean report after reset (070000: parity 1 then 0, 0 when enabled)
    d0 = done_cnt;
    v = 24'h070000;
    u_if.ctr_in = v;
    u_if.report_req = 1'b1;
    push_bytes(v);
    tick();
    u_if.report_req = 1'b0;
    wait_done("t6_done_seen");
    repeat (3) @(negedge clk);
    chk("t6_busy_len", last_busy_len, RC);
    chk("t6_done_pulses", done_cnt - d0, 1);
    chk("t6_sb_empty", sb.size(), 0);

    chk("oeb_low_and_idle_tx_high", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
